// File: rtl/fsm_control_multi.sv
// ---------------------------------------------------------------------------
// fsm_control_multi
//   Flow-control supervisor for NUM_CH FIFO channels. It latches and validates
//   the VCFC threshold pair during INIT and holds it afterwards. It reports
//   idle/active/error status, drops back to IDLE after IDLE_CYCLES consecutive
//   all-empty cycles, and leaves ERROR through clear_err without a full reset.
//
// Ports
//   clk            clock, all state updates on posedge
//   reset_L        synchronous reset, active-high (legacy name kept)
//   init           start configuration while in RESET
//   clear_err      request to leave ERROR (refused while any FIFO error is set)
//   umbral_alto    high (almost-full) threshold, sampled in INIT
//   umbral_bajo    low (almost-empty) threshold, sampled in INIT
//   fifo_error     per-channel FIFO error
//   fifo_empty     per-channel FIFO empty
//   umbral_alto_q  registered high threshold
//   umbral_bajo_q  registered low threshold
//   state_o        encoded state (RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4)
//   idle/active/error  one-hot status decoded from the registered state
//   err_ch         sticky per-channel error flags
//   cfg_err        sticky invalid-configuration flag
// ---------------------------------------------------------------------------
module fsm_control_multi #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned UMBRAL_W    = 8,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned IDLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset_L,
   input  logic                init,
   input  logic                clear_err,
   input  logic [UMBRAL_W-1:0] umbral_alto,
   input  logic [UMBRAL_W-1:0] umbral_bajo,
   input  logic [NUM_CH-1:0]   fifo_error,
   input  logic [NUM_CH-1:0]   fifo_empty,
   output logic [UMBRAL_W-1:0] umbral_alto_q,
   output logic [UMBRAL_W-1:0] umbral_bajo_q,
   output logic [2:0]          state_o,
   output logic                idle,
   output logic                active,
   output logic                error,
   output logic [NUM_CH-1:0]   err_ch,
   output logic                cfg_err
);

   localparam logic [2:0] ST_RESET  = 3'd0;
   localparam logic [2:0] ST_INIT   = 3'd1;
   localparam logic [2:0] ST_IDLE   = 3'd2;
   localparam logic [2:0] ST_ACTIVE = 3'd3;
   localparam logic [2:0] ST_ERROR  = 3'd4;

   localparam int unsigned CNT_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

   // Depth comparison is done at a width that holds both operands, so a
   // FIFO_DEPTH wider than the threshold bus cannot be truncated.
   localparam int unsigned EXT_W = (UMBRAL_W > 32) ? UMBRAL_W : 32;

   logic [2:0]       state;
   logic [CNT_W-1:0] idle_cnt;
   logic             any_err;
   logic             all_empty;
   logic             cfg_ok;
   logic [EXT_W-1:0] alto_ext;
   logic [EXT_W-1:0] depth_ext;

   assign any_err   = |fifo_error;
   assign all_empty = &fifo_empty;
   assign alto_ext  = EXT_W'(umbral_alto);
   assign depth_ext = EXT_W'(FIFO_DEPTH);
   assign cfg_ok    = (umbral_bajo < umbral_alto) && (alto_ext <= depth_ext);

   assign state_o = state;
   assign idle    = (state == ST_IDLE);
   assign active  = (state == ST_ACTIVE);
   assign error   = (state == ST_ERROR);

   always_ff @(posedge clk) begin
      if (reset_L) begin
         state         <= ST_RESET;
         umbral_alto_q <= '0;
         umbral_bajo_q <= '0;
         err_ch        <= '0;
         cfg_err       <= 1'b0;
         idle_cnt      <= '0;
      end else begin
         case (state)
            ST_RESET: begin
               if (init) state <= ST_INIT;
            end

            ST_INIT: begin
               umbral_alto_q <= umbral_alto;
               umbral_bajo_q <= umbral_bajo;
               // A bad config and a FIFO error in the same cycle record both.
               if (!cfg_ok || any_err) begin
                  state <= ST_ERROR;
                  if (!cfg_ok) cfg_err <= 1'b1;
                  if (any_err) err_ch  <= fifo_error;
               end else begin
                  state <= ST_IDLE;
               end
            end

            ST_IDLE: begin
               if (any_err) begin
                  state  <= ST_ERROR;
                  err_ch <= fifo_error;
               end else if (!all_empty) begin
                  state    <= ST_ACTIVE;
                  idle_cnt <= '0;
               end
            end

            ST_ACTIVE: begin
               if (any_err) begin
                  state  <= ST_ERROR;
                  err_ch <= fifo_error;
               end else if (all_empty) begin
                  if (idle_cnt == CNT_LAST) begin
                     state    <= ST_IDLE;
                     idle_cnt <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + CNT_W'(1);
                  end
               end else begin
                  idle_cnt <= '0;
               end
            end

            ST_ERROR: begin
               if (clear_err && !any_err) begin
                  state         <= ST_RESET;
                  err_ch        <= '0;
                  cfg_err       <= 1'b0;
                  umbral_alto_q <= '0;
                  umbral_bajo_q <= '0;
               end else begin
                  err_ch <= err_ch | fifo_error;
               end
            end

            default: state <= ST_RESET;
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_control_multi.sv
// ---------------------------------------------------------------------------
// tb_fsm_control_multi
//   Directed-vector bench for fsm_control_multi with default parameters.
//   The stimulus process pushes the hand-computed post-edge outputs into a
//   queue tagged with the cycle they apply to; a monitor on the falling edge
//   pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_fsm_control_multi;

   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic       init = 1'b0;
   logic       clear_err = 1'b0;
   logic [7:0] umbral_alto = '0;
   logic [7:0] umbral_bajo = '0;
   logic [3:0] fifo_error = '0;
   logic [3:0] fifo_empty = 4'hF;
   logic [7:0] umbral_alto_q;
   logic [7:0] umbral_bajo_q;
   logic [2:0] state_o;
   logic       idle;
   logic       active;
   logic       error;
   logic [3:0] err_ch;
   logic       cfg_err;

   fsm_control_multi #(
      .NUM_CH(4),
      .UMBRAL_W(8),
      .FIFO_DEPTH(16),
      .IDLE_CYCLES(4)
   ) dut (
      .clk(clk),
      .reset_L(reset_L),
      .init(init),
      .clear_err(clear_err),
      .umbral_alto(umbral_alto),
      .umbral_bajo(umbral_bajo),
      .fifo_error(fifo_error),
      .fifo_empty(fifo_empty),
      .umbral_alto_q(umbral_alto_q),
      .umbral_bajo_q(umbral_bajo_q),
      .state_o(state_o),
      .idle(idle),
      .active(active),
      .error(error),
      .err_ch(err_ch),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      string      name;
      logic [2:0] st;
      logic [7:0] alto;
      logic [7:0] bajo;
      logic [3:0] errc;
      logic       cfg;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every expectation whose cycle has been reached.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         exp_t e;
         logic [25:0] act_v, exp_v;
         e = exp_q.pop_front();
         exp_v = {e.st, e.st == 3'd2, e.st == 3'd3, e.st == 3'd4,
                  e.alto, e.bajo, e.errc, e.cfg};
         act_v = {state_o, idle, active, error,
                  umbral_alto_q, umbral_bajo_q, err_ch, cfg_err};
         tests = tests + 1;
         if (act_v !== exp_v || e.cyc != cyc) begin
            fails = fails + 1;
            $display("FAIL %s (cyc %0d): got st=%0d i/a/e=%b%b%b alto=%0d bajo=%0d err_ch=%b cfg=%b, want st=%0d alto=%0d bajo=%0d err_ch=%b cfg=%b",
                     e.name, cyc, state_o, idle, active, error, umbral_alto_q,
                     umbral_bajo_q, err_ch, cfg_err, e.st, e.alto, e.bajo,
                     e.errc, e.cfg);
         end
      end
   end

   // Apply current inputs across one rising edge; expect the given outputs after it.
   task automatic tick(input string name, input logic [2:0] st, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] ec, input logic cf);
      exp_t e;
      e.cyc = cyc + 1; e.name = name; e.st = st;
      e.alto = a; e.bajo = b; e.errc = ec; e.cfg = cf;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset
      reset_L = 1'b1;
      tick("reset", 3'd0, 8'd0, 8'd0, 4'h0, 1'b0);
      reset_L = 1'b0;
      tick("reset_hold", 3'd0, 8'd0, 8'd0, 4'h0, 1'b0);

      // Legal config
      init = 1'b1; umbral_alto = 8'd12; umbral_bajo = 8'd3;
      tick("to_init", 3'd1, 8'd0, 8'd0, 4'h0, 1'b0);
      init = 1'b0;
      tick("init_to_idle", 3'd2, 8'd12, 8'd3, 4'h0, 1'b0);
      umbral_alto = 8'd99; umbral_bajo = 8'd77;
      tick("thresh_hold", 3'd2, 8'd12, 8'd3, 4'h0, 1'b0);

      // Activity then 4 empty cycles back to IDLE
      fifo_empty = 4'b1011;
      tick("idle_to_active", 3'd3, 8'd12, 8'd3, 4'h0, 1'b0);
      fifo_empty = 4'hF;
      tick("empty1", 3'd3, 8'd12, 8'd3, 4'h0, 1'b0);
      tick("empty2", 3'd3, 8'd12, 8'd3, 4'h0, 1'b0);
      tick("empty3", 3'd3, 8'd12, 8'd3, 4'h0, 1'b0);
      tick("empty4_idle", 3'd2, 8'd12, 8'd3, 4'h0, 1'b0);

      // Restart of the idle count by a non-empty pulse
      fifo_empty = 4'b1011;
      tick("reactivate", 3'd3, 8'd12, 8'd3, 4'h0, 1'b0);
      fifo_empty = 4'hF;
      for (int i = 0; i < 3; i++) tick("pre_pulse_empty", 3'd3, 8'd12, 8'd3, 4'h0, 1'b0);
      fifo_empty = 4'b1011;
      tick("pulse_restart", 3'd3, 8'd12, 8'd3, 4'h0, 1'b0);
      fifo_empty = 4'hF;
      for (int i = 0; i < 3; i++) tick("post_pulse_empty", 3'd3, 8'd12, 8'd3, 4'h0, 1'b0);
      tick("post_pulse_idle", 3'd2, 8'd12, 8'd3, 4'h0, 1'b0);

      // Errors in ACTIVE, accumulation in ERROR
      fifo_empty = 4'b0000;
      tick("active_full", 3'd3, 8'd12, 8'd3, 4'h0, 1'b0);
      fifo_error = 4'b0100;
      tick("active_err", 3'd4, 8'd12, 8'd3, 4'b0100, 1'b0);
      fifo_error = 4'b0001;
      tick("err_accum", 3'd4, 8'd12, 8'd3, 4'b0101, 1'b0);
      fifo_error = 4'b0000; fifo_empty = 4'hF; init = 1'b1;
      tick("err_ignore_init", 3'd4, 8'd12, 8'd3, 4'b0101, 1'b0);
      init = 1'b0;

      // Clear refused while an error is present, then accepted
      clear_err = 1'b1; fifo_error = 4'b0010;
      tick("clear_refused", 3'd4, 8'd12, 8'd3, 4'b0111, 1'b0);
      fifo_error = 4'b0000;
      tick("clear_ok", 3'd0, 8'd0, 8'd0, 4'h0, 1'b0);
      clear_err = 1'b0;

      // Reset mid-ACTIVE
      init = 1'b1; umbral_alto = 8'd12; umbral_bajo = 8'd3;
      tick("re_init", 3'd1, 8'd0, 8'd0, 4'h0, 1'b0);
      init = 1'b0;
      tick("re_idle", 3'd2, 8'd12, 8'd3, 4'h0, 1'b0);
      fifo_empty = 4'b1110;
      tick("re_active", 3'd3, 8'd12, 8'd3, 4'h0, 1'b0);
      reset_L = 1'b1;
      tick("reset_in_active", 3'd0, 8'd0, 8'd0, 4'h0, 1'b0);
      reset_L = 1'b0; fifo_empty = 4'hF;

      // Illegal alto above depth
      init = 1'b1; umbral_alto = 8'd17; umbral_bajo = 8'd3;
      tick("bad_alto_init", 3'd1, 8'd0, 8'd0, 4'h0, 1'b0);
      init = 1'b0;
      tick("bad_alto_err", 3'd4, 8'd17, 8'd3, 4'h0, 1'b1);
      clear_err = 1'b1;
      tick("bad_alto_clear", 3'd0, 8'd0, 8'd0, 4'h0, 1'b0);
      clear_err = 1'b0;

      // Illegal bajo == alto
      init = 1'b1; umbral_alto = 8'd3; umbral_bajo = 8'd3;
      tick("eq_init", 3'd1, 8'd0, 8'd0, 4'h0, 1'b0);
      init = 1'b0;
      tick("eq_err", 3'd4, 8'd3, 8'd3, 4'h0, 1'b1);
      clear_err = 1'b1;
      tick("eq_clear", 3'd0, 8'd0, 8'd0, 4'h0, 1'b0);
      clear_err = 1'b0;

      // Boundary legal: alto == depth, bajo == alto-1
      init = 1'b1; umbral_alto = 8'd16; umbral_bajo = 8'd15;
      tick("edge_init", 3'd1, 8'd0, 8'd0, 4'h0, 1'b0);
      init = 1'b0;
      tick("edge_idle", 3'd2, 8'd16, 8'd15, 4'h0, 1'b0);
      fifo_error = 4'b0010; fifo_empty = 4'b0000;
      tick("idle_err_prio", 3'd4, 8'd16, 8'd15, 4'b0010, 1'b0);
      fifo_error = 4'b0000; fifo_empty = 4'hF; clear_err = 1'b1;
      tick("idle_err_clear", 3'd0, 8'd0, 8'd0, 4'h0, 1'b0);
      clear_err = 1'b0;

      // Bad config and FIFO error together in INIT
      init = 1'b1; umbral_alto = 8'd20; umbral_bajo = 8'd3;
      tick("both_init", 3'd1, 8'd0, 8'd0, 4'h0, 1'b0);
      init = 1'b0; fifo_error = 4'b1000;
      tick("both_err", 3'd4, 8'd20, 8'd3, 4'b1000, 1'b1);
      fifo_error = 4'b0000; reset_L = 1'b1; clear_err = 1'b1;
      tick("reset_and_clear", 3'd0, 8'd0, 8'd0, 4'h0, 1'b0);
      reset_L = 1'b0; clear_err = 1'b0;

      @(negedge clk);
      @(negedge clk);
      tests = tests + 1;
      if (exp_q.size() != 0) begin
         fails = fails + 1;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
